bsg_cache_to_axi_dma_arb: RTL



---
 rtl/bsg_cache_to_axi_pkg.sv | 8 +
 rtl/bsg_cache_to_axi_dma_arb_rr.sv | 30 +++
 rtl/bsg_cache_to_axi_dma_arb.sv | 84 ++++++++
 3 files changed

// File: rtl/bsg_cache_to_axi_pkg.sv
// bsg_cache_to_axi_pkg: shared packet/slot layouts and sizing helper for the cache-to-AXI bridge.
`define BSG_CACHE_TO_AXI_DMA_PKT_S(aw) struct packed {logic write_not_read; logic [(aw)-1:0] addr;}
`define BSG_CACHE_TO_AXI_SLOT_S(tw, aw) struct packed {logic [(tw)-1:0] tag; logic [(aw)-1:0] axi_addr;}
package bsg_cache_to_axi_pkg;
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/bsg_cache_to_axi_dma_arb_rr.sv
// bsg_arb_round_robin: one-hot round-robin grant, search starts after the last winner.
module bsg_arb_round_robin
  import bsg_cache_to_axi_pkg::*;
#(
  parameter int width_p = 4,
  parameter int lg_width_lp = safe_clog2(width_p)
)(
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] reqs_i,
  output logic [width_p-1:0] grants_o,
  input  logic               yumi_i
);
  logic [lg_width_lp-1:0] last_r, last_n, idx;
  always_comb begin
    grants_o = '0;
    last_n = last_r;
    idx = '0;
    for (int k = 1; k <= width_p; k++) begin
      idx = lg_width_lp'((int'(last_r) + k) % width_p);
      if (grants_o == '0 && reqs_i[idx]) begin
        grants_o[idx] = 1'b1;
        last_n = idx;
      end
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) last_r <= lg_width_lp'(width_p - 1);
    else if (yumi_i) last_r <= last_n;
endmodule

// File: rtl/bsg_cache_to_axi_dma_arb.sv
// bsg_cache_to_axi_dma_arb: round-robin arbitration of cache DMA packets into one-entry
// read/write request slots carrying block-aligned, cache-tagged AXI addresses.
module bsg_cache_to_axi_dma_arb
  import bsg_cache_to_axi_pkg::*;
#(
  parameter int num_cache_p = 4,
  parameter int addr_width_p = 28,
  parameter int data_width_p = 32,
  parameter int block_size_in_words_p = 8,
  parameter int axi_addr_width_p = 32,
  parameter int lg_num_cache_lp = safe_clog2(num_cache_p),
  parameter int block_offset_width_lp = safe_clog2(block_size_in_words_p * data_width_p / 8),
  parameter int dma_pkt_width_lp = addr_width_p + 1
)(
  input  logic                                         clk_i,
  input  logic                                         reset_n_i,
  input  logic [num_cache_p-1:0][dma_pkt_width_lp-1:0] dma_pkt_i,
  input  logic [num_cache_p-1:0]                       dma_pkt_v_i,
  output logic [num_cache_p-1:0]                       dma_pkt_yumi_o,
  output logic                                         rx_v_o,
  output logic [lg_num_cache_lp-1:0]                   rx_tag_o,
  output logic [axi_addr_width_p-1:0]                  rx_axi_addr_o,
  input  logic                                         rx_yumi_i,
  output logic                                         tx_v_o,
  output logic [lg_num_cache_lp-1:0]                   tx_tag_o,
  output logic [axi_addr_width_p-1:0]                  tx_axi_addr_o,
  input  logic                                         tx_yumi_i
);
  typedef `BSG_CACHE_TO_AXI_DMA_PKT_S(addr_width_p) dma_pkt_s;
  typedef `BSG_CACHE_TO_AXI_SLOT_S(lg_num_cache_lp, axi_addr_width_p) slot_s;
  localparam logic [addr_width_p-1:0] blk_mask_lp = ~addr_width_p'((1 << block_offset_width_lp) - 1);
  dma_pkt_s [num_cache_p-1:0] pkts;
  dma_pkt_s win_pkt;
  slot_s rd_r, wr_r, new_slot;
  logic rd_full_r, wr_full_r, rd_avail, wr_avail, any_grant, ld_rd, ld_wr;
  logic [num_cache_p-1:0] elig, grants;
  logic [lg_num_cache_lp-1:0] win;
  assign pkts = dma_pkt_i;
  // A full slot whose consumer yumis this cycle can be refilled in the same cycle.
  assign rd_avail = ~rd_full_r | rx_yumi_i;
  assign wr_avail = ~wr_full_r | tx_yumi_i;
  always_comb begin
    elig = '0;
    win = '0;
    for (int i = 0; i < num_cache_p; i++) begin
      elig[i] = reset_n_i & dma_pkt_v_i[i] & (pkts[i].write_not_read ? wr_avail : rd_avail);
      win = grants[i] ? lg_num_cache_lp'(i) : win;
    end
  end
  bsg_arb_round_robin #(.width_p(num_cache_p)) arb (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .reqs_i(elig),
    .grants_o(grants),
    .yumi_i(any_grant)
  );
  assign any_grant = |grants;
  assign win_pkt = pkts[win];
  assign ld_rd = any_grant & ~win_pkt.write_not_read;
  assign ld_wr = any_grant & win_pkt.write_not_read;
  assign new_slot.tag = win;
  assign new_slot.axi_addr = axi_addr_width_p'({win, win_pkt.addr & blk_mask_lp});
  assign dma_pkt_yumi_o = grants;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      rd_r <= '0;
      wr_r <= '0;
      rd_full_r <= 1'b0;
      wr_full_r <= 1'b0;
    end else begin
      if (ld_rd) rd_r <= new_slot;
      if (ld_wr) wr_r <= new_slot;
      rd_full_r <= ld_rd | (rd_full_r & ~rx_yumi_i);
      wr_full_r <= ld_wr | (wr_full_r & ~tx_yumi_i);
    end
  assign rx_v_o = rd_full_r;
  assign rx_tag_o = rd_r.tag;
  assign rx_axi_addr_o = rd_r.axi_addr;
  assign tx_v_o = wr_full_r;
  assign tx_tag_o = wr_r.tag;
  assign tx_axi_addr_o = wr_r.axi_addr;
  a_rx_yumi_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(rx_yumi_i && !rd_full_r));
  a_tx_yumi_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(tx_yumi_i && !wr_full_r));
endmodule
